// File: rtl/stopwatch_display.sv
// stopwatch_display: converts the binary stopwatch count to four BCD digits
// with a free-running sequential double-dabble engine, exports the registered
// BCD word, and scans a common-anode 4-digit 7-segment display.
//
// state | meaning
// ------+----------------------------------------------------------------
// IDLE  | sample count, clear scratch and iteration counter, note overflow
// CONV  | one double-dabble iteration per cycle (adjust, then shift)
// LATCH | publish scratch (or dashes on overflow) and pulse bcd_valid
module stopwatch_display #(
    parameter int DATA_WIDTH  = 16,
    parameter int REFRESH_DIV = 100000
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [DATA_WIDTH-1:0] count,
    output logic [15:0]           bcd,
    output logic                  bcd_valid,
    output logic [6:0]            seg,
    output logic [3:0]            an,
    output logic                  dp
);
    localparam int ITER_W = $clog2(DATA_WIDTH);
    localparam int REF_W  = $clog2(REFRESH_DIV);
    localparam logic [ITER_W-1:0] ITER_LAST = ITER_W'(DATA_WIDTH - 1);
    localparam logic [REF_W-1:0]  REF_LAST  = REF_W'(REFRESH_DIV - 1);

    typedef enum logic [1:0] {IDLE, CONV, LATCH} state_t;

    state_t                state;
    state_t                state_next;
    logic [DATA_WIDTH-1:0] shift_reg;
    logic [15:0]           scratch;
    logic [15:0]           scratch_adj;
    logic [ITER_W-1:0]     iter;
    logic                  ovf;
    logic [REF_W-1:0]      ref_cnt;
    logic                  ref_wrap;
    logic [1:0]            sel;
    logic [1:0]            sel_next;

    // active-low gfedcba patterns; 4'hA is a dash, B..F are blank
    function automatic logic [6:0] seg_decode(input logic [3:0] digit);
        logic [6:0] pat;
        case (digit)
            4'h0:    pat = 7'b1000000;
            4'h1:    pat = 7'b1111001;
            4'h2:    pat = 7'b0100100;
            4'h3:    pat = 7'b0110000;
            4'h4:    pat = 7'b0011001;
            4'h5:    pat = 7'b0010010;
            4'h6:    pat = 7'b0000010;
            4'h7:    pat = 7'b1111000;
            4'h8:    pat = 7'b0000000;
            4'h9:    pat = 7'b0010000;
            4'hA:    pat = 7'b0111111;
            default: pat = 7'b1111111;
        endcase
        return pat;
    endfunction

    // conversion FSM state register
    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    // conversion FSM next-state logic
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    state_next = CONV;
            CONV:    if (iter == ITER_LAST) state_next = LATCH;
            LATCH:   state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // add-3 correction of every scratch nibble that is 5 or more
    always_comb begin
        scratch_adj = scratch;
        for (int i = 0; i < 4; i++) begin
            if (scratch[i*4 +: 4] >= 4'd5)
                scratch_adj[i*4 +: 4] = scratch[i*4 +: 4] + 4'd3;
        end
    end

    // double-dabble datapath and BCD output register; scratch may wrap for
    // values above 9999, which is fine because ovf discards the result
    always_ff @(posedge clk) begin
        if (reset) begin
            shift_reg <= '0;
            scratch   <= '0;
            iter      <= '0;
            ovf       <= 1'b0;
            bcd       <= '0;
            bcd_valid <= 1'b0;
        end else begin
            bcd_valid <= 1'b0;
            case (state)
                IDLE: begin
                    shift_reg <= count;
                    scratch   <= '0;
                    iter      <= '0;
                    ovf       <= (32'(count) > 32'd9999);
                end
                CONV: begin
                    scratch   <= {scratch_adj[14:0], shift_reg[DATA_WIDTH-1]};
                    shift_reg <= shift_reg << 1;
                    iter      <= iter + ITER_W'(1);
                end
                LATCH: begin
                    bcd       <= ovf ? 16'hAAAA : scratch;
                    bcd_valid <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign ref_wrap = (ref_cnt == REF_LAST);
    assign sel_next = ref_wrap ? sel + 2'd1 : sel;

    // digit scan: an and seg are both driven from sel_next so they switch together
    always_ff @(posedge clk) begin
        if (reset) begin
            ref_cnt <= '0;
            sel     <= 2'd0;
            an      <= 4'b1110;
            seg     <= 7'b1000000;
        end else begin
            ref_cnt <= ref_wrap ? '0 : ref_cnt + REF_W'(1);
            sel     <= sel_next;
            an      <= ~(4'b0001 << sel_next);
            seg     <= seg_decode(bcd[{sel_next, 2'b00} +: 4]);
        end
    end

    assign dp = 1'b1;

endmodule

// File: tb/tb_stopwatch_display.sv
// tb_stopwatch_display: table of count values plus hand-written sequences;
// a scoreboard predicts each BCD result and its due cycle when the sample is taken.
module tb_stopwatch_display;
    localparam int DW = 16;
    localparam int RD = 4;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic [DW-1:0] count = '0;
    logic [15:0]   bcd;
    logic          bcd_valid;
    logic [6:0]    seg;
    logic [3:0]    an;
    logic          dp;

    stopwatch_display #(.DATA_WIDTH(DW), .REFRESH_DIV(RD)) dut (
        .clk       (clk),
        .reset     (reset),
        .count     (count),
        .bcd       (bcd),
        .bcd_valid (bcd_valid),
        .seg       (seg),
        .an        (an),
        .dp        (dp)
    );

    always #5 clk = ~clk;

    typedef struct { logic [15:0] val; int due; } sb_t;
    typedef struct { logic [DW-1:0] cnt; logic [15:0] exp; } vec_t;

    sb_t         q[$];
    logic [15:0] log_q[$];
    vec_t        vec[7];

    int          total = 0;
    int          bad = 0;
    int          cyc = 0;
    int          phase = 0;
    int          mcnt = 0;
    logic [1:0]  msel = 2'd0;
    logic [15:0] mbcd = 16'h0000;
    logic [6:0]  exp_seg = 7'b1000000;
    logic [3:0]  exp_an = 4'b1110;

    function automatic logic [15:0] model_bcd(input int unsigned v);
        if (v > 9999) return 16'hAAAA;
        return {4'(v / 1000), 4'((v / 100) % 10), 4'((v / 10) % 10), 4'(v % 10)};
    endfunction

    function automatic logic [6:0] dec(input logic [3:0] d);
        case (d)
            4'd0: return 7'b1000000;
            4'd1: return 7'b1111001;
            4'd2: return 7'b0100100;
            4'd3: return 7'b0110000;
            4'd4: return 7'b0011001;
            4'd5: return 7'b0010010;
            4'd6: return 7'b0000010;
            4'd7: return 7'b1111000;
            4'd8: return 7'b0000000;
            4'd9: return 7'b0010000;
            4'hA: return 7'b0111111;
            default: return 7'b1111111;
        endcase
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // one clock: update the model at the rising edge, compare at the falling edge
    task automatic tick();
        sb_t e;
        @(posedge clk);
        cyc++;
        if (reset) begin
            phase = 0;
            q.delete();
            mcnt = 0;
            msel = 2'd0;
            mbcd = 16'h0000;
            exp_seg = dec(4'd0);
        end else begin
            if (phase == 0) q.push_back('{val: model_bcd(32'(count)), due: cyc + DW + 1});
            phase = (phase == DW + 1) ? 0 : phase + 1;
            if (mcnt == RD - 1) begin
                mcnt = 0;
                msel = msel + 2'd1;
            end else begin
                mcnt++;
            end
            exp_seg = dec(mbcd[{msel, 2'b00} +: 4]);
            if (q.size() > 0 && q[0].due == cyc) mbcd = q[0].val;
        end
        exp_an = ~(4'b0001 << msel);
        @(negedge clk);
        if (bcd_valid) begin
            if (q.size() == 0) begin
                chk("spurious_valid", 32'(bcd_valid), 32'd0);
            end else begin
                e = q.pop_front();
                chk("bcd", 32'(bcd), 32'(e.val));
                chk("valid_cycle", cyc, e.due);
                log_q.push_back(bcd);
            end
        end else if (q.size() > 0 && cyc >= q[0].due) begin
            chk("missing_valid", 32'(bcd_valid), 32'd1);
            void'(q.pop_front());
        end
        chk("an", 32'(an), 32'(exp_an));
        chk("seg", 32'(seg), 32'(exp_seg));
        chk("dp", 32'(dp), 32'd1);
    endtask

    initial begin
        int          n;
        int          pulses;
        logic        found;
        logic [3:0]  prev_an;
        logic [3:0]  scan_an[4];
        logic [6:0]  scan_seg[4];

        vec[0] = '{16'd47,    16'h0047};
        vec[1] = '{16'd99,    16'h0099};
        vec[2] = '{16'd0,     16'h0000};
        vec[3] = '{16'd9999,  16'h9999};
        vec[4] = '{16'd10000, 16'hAAAA};
        vec[5] = '{16'd65535, 16'hAAAA};
        vec[6] = '{16'd1234,  16'h1234};
        scan_an[0] = 4'b1110;  scan_seg[0] = 7'b0011001;
        scan_an[1] = 4'b1101;  scan_seg[1] = 7'b0110000;
        scan_an[2] = 4'b1011;  scan_seg[2] = 7'b0100100;
        scan_an[3] = 4'b0111;  scan_seg[3] = 7'b1111001;

        // reset values
        reset = 1'b1;
        count = 16'd47;
        repeat (3) tick();
        chk("rst_bcd", 32'(bcd), 32'h0000);
        chk("rst_valid", 32'(bcd_valid), 32'd0);
        chk("rst_an", 32'(an), 32'b1110);
        chk("rst_seg", 32'(seg), 32'b1000000);
        chk("rst_dp", 32'(dp), 32'd1);

        // first-result latency and repeat period
        reset = 1'b0;
        n = 0;
        for (int i = 0; i < 40; i++) begin
            tick();
            n++;
            if (bcd_valid) break;
        end
        chk("latency", n, 18);
        chk("latency_bcd", 32'(bcd), 32'h0047);
        n = 0;
        for (int i = 0; i < 40; i++) begin
            tick();
            n++;
            if (bcd_valid) break;
        end
        chk("period", n, 18);

        // table of values, including boundaries and overflow
        for (int i = 0; i < 7; i++) begin
            count = vec[i].cnt;
            repeat (40) tick();
            chk("table_bcd", 32'(bcd), 32'(vec[i].exp));
            for (int k = 0; k < 4 * RD; k++) begin
                tick();
                if (vec[i].exp == 16'hAAAA) chk("dash_seg", 32'(seg), 32'b0111111);
            end
        end

        // full scan of 1234: each digit held RD cycles, ones digit first
        found = 1'b0;
        for (int i = 0; i < 20; i++) begin
            prev_an = an;
            tick();
            if (an == 4'b1110 && prev_an == 4'b0111) begin
                found = 1'b1;
                break;
            end
        end
        chk("scan_sync", 32'(found), 32'd1);
        for (int i = 0; i < 4 * RD; i++) begin
            chk("scan_an", 32'(an), 32'(scan_an[i / RD]));
            chk("scan_seg", 32'(seg), 32'(scan_seg[i / RD]));
            tick();
        end

        // count changes while converting: old value finishes first
        count = 16'd12;
        for (int i = 0; i < 25; i++) begin
            tick();
            if (phase == 1) break;
        end
        log_q.delete();
        repeat (3) tick();
        count = 16'd34;
        repeat (40) tick();
        chk("midconv_pulses", 32'(log_q.size() >= 2), 32'd1);
        if (log_q.size() >= 2) begin
            chk("midconv_first", 32'(log_q[0]), 32'h0012);
            chk("midconv_second", 32'(log_q[1]), 32'h0034);
        end

        // reset in the middle of a conversion: no write, no pulse
        reset = 1'b1;
        repeat (3) tick();
        chk("abort_pre_bcd", 32'(bcd), 32'h0000);
        reset = 1'b0;
        count = 16'd5555;
        repeat (6) tick();
        reset = 1'b1;
        repeat (2) tick();
        reset = 1'b0;
        pulses = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (bcd_valid) pulses++;
            chk("abort_bcd", 32'(bcd), 32'h0000);
        end
        chk("abort_pulses", pulses, 0);
        repeat (30) tick();
        chk("after_abort_bcd", 32'(bcd), 32'h5555);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/stopwatch_display.md
# stopwatch_display

Display back-end for the stopwatch counter. Converts the binary `count` value into four BCD digits using a sequential double-dabble engine, then drives a common-anode, time-multiplexed 4-digit 7-segment display. It sits directly downstream of the stopwatch counter and continuously re-samples the count, with no handshake required from the counter. A registered BCD word is also exported for other consumers.

## Interface
- `DATA_WIDTH`, 16, width of `count`; legal range 4..32.
- `REFRESH_DIV`, 100000, clk cycles each digit stays lit; must be ≥ 2.
- `clk`  in  1  clock; all state updates on the rising edge.
- `reset`  in  1  synchronous, active-high.
- `count`  in  DATA_WIDTH  unsigned binary value from the counter.
- `bcd`  out  16  registered BCD; [3:0] ones … [15:12] thousands; nibble 4'hA means dash.
- `bcd_valid`  out  1  one-cycle pulse when `bcd` is written.
- `seg`  out  7  active-low segments; seg[0]=a … seg[6]=g.
- `an`  out  4  active-low digit enables, one-hot-low; an[0]=ones.
- `dp`  out  1  decimal point, active-low; held 1 (off).

## Operation
- Conversion FSM has three states: IDLE, CONV, LATCH.
- IDLE (one cycle):
  - load shift register with `count`; clear the 16-bit BCD scratch; clear iteration counter.
  - set `ovf` = (`count` > 9999); go to CONV.
- CONV:
  - each cycle, first add 3 to every scratch nibble ≥ 5.
  - then shift {scratch, shift register} left by 1.
  - after exactly DATA_WIDTH iterations, go to LATCH.
- LATCH:
  - if `ovf`, write `bcd` = 16'hAAAA; otherwise write `bcd` = scratch.
  - pulse `bcd_valid` = 1; go to IDLE.
- Conversion repeats free-running. `count` is only sampled in IDLE; changes during CONV/LATCH are ignored until the next IDLE.
- Scratch overflow for values > 9999 is harmless because the result is discarded via `ovf`.
- Refresh counter runs 0..REFRESH_DIV-1 and wraps.
  - On wrap, digit select advances 0→1→2→3→0.
  - `an` = ~(1 << sel).
  - `seg` decodes `bcd` nibble `sel`, registered.
- Segment decode (active-low, gfedcba):
  - 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001.
  - 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000.
  - A (dash)=0111111; B–F blank = 1111111.
- No leading-zero blanking; count 7 displays "0007".

## Timing
- Reset values:
  - FSM=IDLE; `bcd`=16'h0000; `bcd_valid`=0.
  - refresh counter=0; sel=0; `an`=4'b1110; `seg`=7'b1000000; `dp`=1.
- Reset mid-conversion aborts immediately, with no `bcd` write. The first sample is taken on the first edge with `reset` low.
- Latency: `count` sampled at IDLE edge k → `bcd` updated and `bcd_valid` high after edge k+DATA_WIDTH+1.
- Conversion period is DATA_WIDTH+2 cycles. `bcd_valid` pulses exactly once per period.
- `seg`/`an` reflect the new `bcd` no later than 1 cycle after the `bcd` update for the currently selected digit.
- `an` and `seg` change on the same edge; there are never two digits enabled at once.
- Each digit is lit for exactly REFRESH_DIV cycles; full scan takes 4·REFRESH_DIV cycles.

## Test plan
- Reset check: assert reset 3 cycles → `bcd`=0000, `an`=1110, `seg`=1000000, `dp`=1, `bcd_valid`=0.
- Conversion latency: DATA_WIDTH=16, hold `count`=47 from reset release → `bcd`=16'h0047 with `bcd_valid` high exactly 18 cycles after release. Repeat pulses every 18 cycles.
- Boundary values: `count`=99, 0, 9999 in turn → `bcd`=0099, 0000, 9999.
- Overflow: `count`=10000 and 65535 → `bcd`=AAAA; every digit `seg`=0111111.
- Refresh scan: REFRESH_DIV=4, `count`=1234 → `an` sequence 1110,1101,1011,0111, each held 4 cycles, with `seg` = 4,3,2,1 patterns respectively.
- Mid-conversion events:
  - change `count` 12→34 during CONV → next `bcd`=0012, following `bcd`=0034.
  - assert reset mid-CONV → `bcd` stays 0000, no `bcd_valid` pulse.
